// File: rtl/and_resp_checker.sv
// Response checker for a 2-input AND gate: compares observed C against A&B per sample,
// counting vectors and mismatches, recording first failure index and input coverage.
module and_resp_checker #(
    parameter int unsigned N_VECTORS = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             err_flag,
    output logic [3:0]       coverage
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECTORS - 1);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [3:0]       coverage_q, coverage_d;

    logic sample_c;
    logic clear_c;
    logic mismatch_c;

    assign sample_c   = valid && (state_q == ST_RUN);
    assign clear_c    = start && (state_q != ST_RUN);
    assign mismatch_c = (C != (A & B));

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_flag_q      <= 1'b0;
            vec_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            coverage_q      <= 4'b0000;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            err_flag_q      <= err_flag_d;
            vec_count_q     <= vec_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            coverage_q      <= coverage_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (valid && (vec_count_q == LAST_IDX)) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        busy_d          = (state_d == ST_RUN);
        done_d          = (state_d == ST_DONE);
        pass_d          = pass_q;
        err_flag_d      = err_flag_q;
        vec_count_d     = vec_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        coverage_d      = coverage_q;

        if (clear_c) begin
            pass_d          = 1'b0;
            err_flag_d      = 1'b0;
            vec_count_d     = '0;
            err_count_d     = '0;
            first_err_idx_d = '0;
            coverage_d      = 4'b0000;
        end else if (sample_c) begin
            vec_count_d          = vec_count_q + CNT_W'(1);
            coverage_d[{A, B}]   = 1'b1;
            if (mismatch_c) begin
                err_count_d = err_count_q + CNT_W'(1);
                err_flag_d  = 1'b1;
                if (!err_flag_q) first_err_idx_d = vec_count_q;
            end
            // Verdict is captured on the edge that takes the final sample
            if (state_d == ST_DONE)
                pass_d = (err_count_d == '0) && (coverage_d == 4'b1111);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_flag      = err_flag_q;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign coverage      = coverage_q;

endmodule

// File: tb/tb_and_resp_checker.sv
// Directed bench for and_resp_checker: one N=4/CNT_W=8 instance and one N=8/CNT_W=4 instance.
module tb_and_resp_checker;

    logic clk = 1'b0;
    logic rst, start, valid, A, B, C;

    logic       busy4, done4, pass4, flag4;
    logic [7:0] vec4, err4, fe4;
    logic [3:0] cov4;

    logic       busy8, done8, pass8, flag8;
    logic [3:0] vec8, err8, fe8;
    logic [3:0] cov8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    and_resp_checker #(.N_VECTORS(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .A(A), .B(B), .C(C),
        .busy(busy4), .done(done4), .pass(pass4), .vec_count(vec4), .err_count(err4),
        .first_err_idx(fe4), .err_flag(flag4), .coverage(cov4)
    );

    and_resp_checker #(.N_VECTORS(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .A(A), .B(B), .C(C),
        .busy(busy8), .done(done8), .pass(pass8), .vec_count(vec8), .err_count(err8),
        .first_err_idx(fe8), .err_flag(flag8), .coverage(cov8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v,
                         input logic a, input logic b, input logic c);
        rst = r; start = s; valid = v; A = a; B = b; C = c;
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic a, input logic b, input logic c);
        drive(1'b0, 1'b0, 1'b1, a, b, c);
    endtask

    task automatic gap();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exhaustive_ok();
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        smp(1'b1, 1'b0, 1'b0);
        smp(1'b1, 1'b1, 1'b1);
    endtask

    task automatic chk_all_zero4(input string tag);
        chk({tag, "_busy"}, 32'(busy4), 32'd0);
        chk({tag, "_done"}, 32'(done4), 32'd0);
        chk({tag, "_pass"}, 32'(pass4), 32'd0);
        chk({tag, "_flag"}, 32'(flag4), 32'd0);
        chk({tag, "_vec"},  32'(vec4),  32'd0);
        chk({tag, "_err"},  32'(err4),  32'd0);
        chk({tag, "_fe"},   32'(fe4),   32'd0);
        chk({tag, "_cov"},  32'(cov4),  32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; A = 1'b0; B = 1'b0; C = 1'b0;

        // Reset state
        do_reset();
        chk_all_zero4("rst");
        chk("rst8_vec", 32'(vec8), 32'd0);

        // Exhaustive correct run
        gap();
        go();
        chk("t1_busy", 32'(busy4), 32'd1);
        chk("t1_vec0", 32'(vec4), 32'd0);
        exhaustive_ok();
        chk("t1_done", 32'(done4), 32'd1);
        chk("t1_busy_off", 32'(busy4), 32'd0);
        chk("t1_pass", 32'(pass4), 32'd1);
        chk("t1_err", 32'(err4), 32'd0);
        chk("t1_cov", 32'(cov4), 32'hf);
        chk("t1_vec", 32'(vec4), 32'd4);
        chk("t1_flag", 32'(flag4), 32'd0);
        smp(1'b1, 1'b1, 1'b0);
        chk("t1_done_hold", 32'(done4), 32'd1);
        chk("t1_pass_hold", 32'(pass4), 32'd1);
        chk("t1_valid_ign", 32'(err4), 32'd0);

        // Stuck-at-0 on the 11 sample, restarted from DONE
        go();
        chk("t2_pass_clr", 32'(pass4), 32'd0);
        chk("t2_vec_clr", 32'(vec4), 32'd0);
        chk("t2_cov_clr", 32'(cov4), 32'd0);
        chk("t2_busy", 32'(busy4), 32'd1);
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        smp(1'b1, 1'b0, 1'b0);
        smp(1'b1, 1'b1, 1'b0);
        chk("t2_err", 32'(err4), 32'd1);
        chk("t2_flag", 32'(flag4), 32'd1);
        chk("t2_fe", 32'(fe4), 32'd3);
        chk("t2_pass", 32'(pass4), 32'd0);
        chk("t2_cov", 32'(cov4), 32'hf);
        chk("t2_done", 32'(done4), 32'd1);

        // Incomplete coverage
        go();
        for (int i = 0; i < 4; i++) smp(1'b0, 1'b0, 1'b0);
        chk("t3_err", 32'(err4), 32'd0);
        chk("t3_cov", 32'(cov4), 32'h1);
        chk("t3_pass", 32'(pass4), 32'd0);
        chk("t3_done", 32'(done4), 32'd1);

        // Valid in IDLE ignored, gapped samples, start mid-RUN ignored
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_idle_vec", 32'(vec4), 32'd0);
        chk("t4_idle_err", 32'(err4), 32'd0);
        chk("t4_idle_busy", 32'(busy4), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_start_vec", 32'(vec4), 32'd0);
        chk("t4_start_err", 32'(err4), 32'd0);
        chk("t4_start_busy", 32'(busy4), 32'd1);
        smp(1'b0, 1'b0, 1'b0);
        gap(); gap();
        smp(1'b0, 1'b1, 1'b0);
        gap(); go();
        chk("t4_mid_start_vec", 32'(vec4), 32'd2);
        chk("t4_mid_start_busy", 32'(busy4), 32'd1);
        smp(1'b1, 1'b0, 1'b0);
        gap(); gap();
        chk("t4_done_early", 32'(done4), 32'd0);
        smp(1'b1, 1'b1, 1'b1);
        chk("t4_done", 32'(done4), 32'd1);
        chk("t4_vec", 32'(vec4), 32'd4);
        chk("t4_pass", 32'(pass4), 32'd1);

        // Reset mid-run discards the partial run
        go();
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b1, 1'b1, 1'b0);
        chk("t5_pre_err", 32'(err4), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all_zero4("t5_rst");
        gap();
        go();
        exhaustive_ok();
        chk("t5_pass", 32'(pass4), 32'd1);
        chk("t5_err", 32'(err4), 32'd0);

        // Back-to-back runs on the N=8, CNT_W=4 instance
        do_reset();
        gap();
        go();
        for (int i = 0; i < 8; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            smp(ab[1], ab[0], ~(ab[1] & ab[0]));
        end
        chk("t6_r1_err", 32'(err8), 32'd8);
        chk("t6_r1_fe", 32'(fe8), 32'd0);
        chk("t6_r1_flag", 32'(flag8), 32'd1);
        chk("t6_r1_pass", 32'(pass8), 32'd0);
        chk("t6_r1_done", 32'(done8), 32'd1);
        chk("t6_r1_vec", 32'(vec8), 32'd8);
        go();
        chk("t6_restart_err", 32'(err8), 32'd0);
        chk("t6_restart_busy", 32'(busy8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            smp(ab[1], ab[0], ab[1] & ab[0]);
        end
        chk("t6_r2_err", 32'(err8), 32'd0);
        chk("t6_r2_fe", 32'(fe8), 32'd0);
        chk("t6_r2_pass", 32'(pass8), 32'd1);
        chk("t6_r2_cov", 32'(cov8), 32'hf);
        chk("t6_r2_done", 32'(done8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/and_resp_checker.md
Name: and_resp_checker

Overview:
- Response-side companion to the 2-input AND gate stimulus bench. It samples a stream of (A, B, C) vectors, where C is the observed output of the gate under test.
- Each sample is compared against the golden A&B. The block counts vectors and mismatches, records the index of the first failure, and tracks coverage of the four input combinations.
- It sits beside any gate-level AND instance, either in a self-checking bench or as an on-chip BIST observer, and gives a single pass/fail verdict per run.

Parameters:
- N_VECTORS, 4, number of valid samples per run. Legal range is 1..2^CNT_W-1.
- CNT_W, 8, width of the vector counter, error counter and index fields.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous and active-high
- start  input  1  begin a new run (one-cycle pulse)
- valid  input  1  A/B/C are a sample this cycle
- A  input  1  gate input A
- B  input  1  gate input B
- C  input  1  observed gate output
- busy  output  1  high while state is RUN
- done  output  1  high while state is DONE
- pass  output  1  verdict, meaningful only while done=1
- vec_count  output  CNT_W  valid samples taken this run
- err_count  output  CNT_W  mismatches this run
- first_err_idx  output  CNT_W  vec_count value at the first mismatch
- err_flag  output  1  at least one mismatch this run
- coverage  output  4  bit {A,B} set once that combination has been sampled

Behaviour:
- Reset, sampled at a rising clk edge with rst=1:
  - state=IDLE.
  - busy=0, done=0, pass=0, err_flag=0.
  - vec_count=0, err_count=0, first_err_idx=0, coverage=4'b0000.
  - rst has priority over every other input.
- States: IDLE, RUN, DONE. Encoding is free; busy and done are registered state decodes.
- IDLE:
  - start=1 moves to RUN and clears all counters, err_flag and coverage.
  - valid is ignored in IDLE, including a valid in the same cycle as start. Sampling begins the cycle after start.
- RUN, at each edge with valid=1:
  - vec_count <= vec_count+1.
  - coverage[{A,B}] <= 1.
  - Mismatch is defined as C != (A & B).
  - On mismatch: err_count <= err_count+1 and err_flag <= 1.
  - On the first mismatch of the run only (err_flag was 0): first_err_idx <= current (pre-increment) vec_count.
- RUN, other rules:
  - valid=0 cycles change nothing; gaps of any length are legal.
  - The edge that takes sample number N_VECTORS also moves the state to DONE. All updates from that sample land on the same edge.
  - start during RUN is ignored; the run is not restarted.
- DONE:
  - done=1 is held.
  - pass = (err_count==0) && (coverage==4'b1111). It is registered on the RUN->DONE edge and held while in DONE.
  - valid is ignored.
  - start=1 clears counters, err_flag, coverage and pass, and moves to RUN.
  - There is no automatic return to IDLE.
- Latency: all counter, flag and coverage updates are visible the cycle after the sampling edge. There is no combinational path from any input to any output.
- Reset mid-run: all state is cleared on that edge and the partial run is discarded.
- X on C is treated as a mismatch-free compare in synthesis. The bench drives only 0/1.

Test Plan:
- Exhaustive correct run, N_VECTORS=4: start, then valid samples (A,B,C)=00/0, 01/0, 10/0, 11/1 -> done=1, pass=1, err_count=0, coverage=1111, vec_count=4, err_flag=0.
- Stuck-at-0 output: same stimulus but C=0 on the 11 sample -> err_count=1, err_flag=1, first_err_idx=3, pass=0, coverage=1111.
- Incomplete coverage: four valid samples of 00/0 -> err_count=0, coverage=0001, pass=0, done=1.
- Gapped valid plus ignored controls:
  - valid held high in IDLE for 3 cycles, then start, then the exhaustive vectors with 2-cycle valid=0 gaps and a start pulse mid-RUN -> vec_count=4 at DONE, pass=1.
  - Done asserts exactly one cycle after the 4th valid edge.
- Reset mid-run: rst asserted after 2 samples, one of them a mismatch -> next cycle all outputs are 0 and state is IDLE. A fresh start plus exhaustive correct vectors -> pass=1, err_count=0.
- Back-to-back runs with N_VECTORS=8, CNT_W=4:
  - Run 1 is all-wrong (C inverted on every sample) -> err_count=8, first_err_idx=0.
  - A start in DONE, then a correct 8-vector run -> err_count=0, first_err_idx=0, pass=1.
